// File: rtl/pe2ddr_wr_pkg.sv
// pe2ddr_wr_pkg: shared widths and helpers for the PE-to-DDR write-back engine.
// Supplies the global datapath widths (DATA_W, BATCH, DDR_W, DDR_ADDR_W,
// BURST_W), the bw() bit-width helper and the address FSM state type.
package pe2ddr_wr_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BATCH      = 4;
  localparam int unsigned DDR_W      = 128;
  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned BURST_W    = 8;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned bw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    A_IDLE,
    A_ISSUE,
    A_WAIT_DATA
  } addr_state_t;

endpackage

// File: rtl/pe2ddr_wr_fifo.sv
// pe2ddr_fifo: synchronous beat FIFO with occupancy count.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write side (dropped when full)
//   pop             read side, advances head when not empty
//   head            current head entry (valid when count != 0)
//   count           number of stored entries, 0..DEPTH
module pe2ddr_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != FULL);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pe2ddr_wr.sv
// pe2ddr_wr: drains one PE accumulation buffer, packs RATIO buffer words per
// DDR beat (first word in the LSBs) and streams the beats to a DDR write-data
// channel while issuing strided burst addresses on the address channel.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start/busy/done     config strobe, activity flag, completion pulse
//   conf_*              transfer configuration, latched on accepted start
//   buf_rd_*            one-hot buffer read port, data 1 cycle after enable
//   ddr_addr*/ddr_size  burst address channel (valid/ready)
//   ddr_wr_*            write-data channel (valid/ready, last per burst)
module pe2ddr_wr
  import pe2ddr_wr_pkg::*;
#(
  parameter int unsigned BUF_DEPTH  = 256,
  parameter int unsigned PE_NUM     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  input  logic [DDR_ADDR_W-1:0]     conf_st_addr,
  input  logic [DDR_ADDR_W-1:0]     conf_step,
  input  logic [BURST_W-1:0]        conf_burst,
  input  logic [BURST_W-1:0]        conf_burst_num,
  input  logic [bw(PE_NUM)-1:0]     conf_pe_sel,
  input  logic [bw(BUF_DEPTH)-1:0]  conf_buf_addr,
  output logic [PE_NUM-1:0]         buf_rd_en,
  output logic [bw(BUF_DEPTH)-1:0]  buf_rd_addr,
  input  logic [DATA_W*BATCH-1:0]   buf_rd_data,
  output logic [DDR_ADDR_W-1:0]     ddr_addr,
  output logic [BURST_W-1:0]        ddr_size,
  output logic                      ddr_addr_valid,
  input  logic                      ddr_addr_ready,
  output logic [DDR_W-1:0]          ddr_wr_data,
  output logic                      ddr_wr_last,
  output logic                      ddr_wr_valid,
  input  logic                      ddr_wr_ready
);

  localparam int unsigned RD_W   = DATA_W * BATCH;
  localparam int unsigned RATIO  = DDR_W / RD_W;
  localparam int unsigned PE_W   = bw(PE_NUM);
  localparam int unsigned BA_W   = bw(BUF_DEPTH);
  localparam int unsigned IDX_W  = bw(RATIO);
  localparam int unsigned BEAT_W = 2 * BURST_W;
  localparam int unsigned TOT_W  = 2 * BURST_W + IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((RATIO < 1) || (DDR_W % RD_W != 0)) begin : g_bad_ratio
    $error("pe2ddr_wr: DDR_W must be an integer multiple of DATA_W*BATCH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pe2ddr_wr: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  addr_state_t           a_state;
  logic [DDR_ADDR_W-1:0] step_q;
  logic [BURST_W-1:0]    addr_left;
  logic [BURST_W-1:0]    burst_q;
  logic [BEAT_W-1:0]     beats_left;
  logic [PE_W-1:0]       pe_sel_q;
  logic [BA_W-1:0]       rd_ptr;
  logic [TOT_W-1:0]      rd_left;
  logic [IDX_W-1:0]      nxt_idx;
  logic [IDX_W-1:0]      pk_idx;
  logic [CNT_W-1:0]      asm_cnt;
  logic                  rd_vld;
  logic [DDR_W-1:0]      pack_q;
  logic [BURST_W-1:0]    wb_idx;

  logic                  start_ok, zero_cfg;
  logic                  a_fire, wr_fire, push, push_last;
  logic                  beat_open, room, can_issue, finish;
  logic [DDR_W-1:0]      push_data;
  logic [DDR_W:0]        fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [BURST_W-1:0]    addr_left_nxt;
  logic [BEAT_W-1:0]     beats_left_nxt;
  logic [TOT_W-1:0]      total_reads;
  logic [BEAT_W-1:0]     total_beats;

  function automatic logic [BA_W-1:0] ptr_inc(input logic [BA_W-1:0] p);
    return (p == BA_W'(BUF_DEPTH - 1)) ? '0 : p + BA_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  assign start_ok    = start && !busy;
  assign zero_cfg    = (conf_burst == '0) || (conf_burst_num == '0);
  assign total_reads = TOT_W'(conf_burst) * TOT_W'(conf_burst_num) * TOT_W'(RATIO);
  assign total_beats = BEAT_W'(conf_burst) * BEAT_W'(conf_burst_num);

  assign ddr_wr_valid = (fifo_count != '0);
  assign ddr_wr_data  = ddr_wr_valid ? fifo_head[DDR_W-1:0] : '0;
  assign ddr_wr_last  = ddr_wr_valid && fifo_head[DDR_W];

  assign a_fire  = ddr_addr_valid && ddr_addr_ready;
  assign wr_fire = ddr_wr_valid && ddr_wr_ready;

  assign push      = rd_vld && (pk_idx == LAST_IDX);
  assign push_last = (wb_idx == burst_q - BURST_W'(1));

  // The final word of a beat goes straight into the FIFO without a pack cycle.
  always_comb begin
    push_data = pack_q;
    push_data[(RATIO-1)*RD_W +: RD_W] = buf_rd_data;
  end

  // A beat counts as "in assembly" from its first read until its push, so the
  // FIFO can never be over-committed even with reads still in flight.
  assign beat_open = (nxt_idx != '0);
  assign room      = ({1'b0, fifo_count} + {1'b0, asm_cnt}) < (CNT_W+1)'(FIFO_DEPTH);
  assign can_issue = busy && (rd_left != '0) && (beat_open || room);

  assign addr_left_nxt  = addr_left - BURST_W'(a_fire);
  assign beats_left_nxt = beats_left - BEAT_W'(wr_fire);
  assign finish         = busy && (addr_left_nxt == '0) && (beats_left_nxt == '0);

  pe2ddr_fifo #(
    .WIDTH (DDR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_last, push_data}),
    .pop       (ddr_wr_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Control: busy/done and the data-channel beat budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      beats_left <= '0;
    end else if (start_ok) begin
      done       <= zero_cfg;
      busy       <= !zero_cfg;
      beats_left <= zero_cfg ? '0 : total_beats;
    end else begin
      done       <= finish;
      beats_left <= beats_left_nxt;
      if (finish) busy <= 1'b0;
    end
  end

  // Address channel FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_state        <= A_IDLE;
      ddr_addr       <= '0;
      ddr_size       <= '0;
      ddr_addr_valid <= 1'b0;
      addr_left      <= '0;
      step_q         <= '0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (start_ok && !zero_cfg) begin
            a_state        <= A_ISSUE;
            ddr_addr       <= conf_st_addr;
            ddr_size       <= conf_burst;
            ddr_addr_valid <= 1'b1;
            addr_left      <= conf_burst_num;
            step_q         <= conf_step;
          end
        end
        A_ISSUE: begin
          if (a_fire) begin
            addr_left <= addr_left_nxt;
            if (addr_left == BURST_W'(1)) begin
              ddr_addr_valid <= 1'b0;
              ddr_addr       <= '0;
              ddr_size       <= '0;
              a_state        <= finish ? A_IDLE : A_WAIT_DATA;
            end else begin
              ddr_addr <= ddr_addr + step_q;
            end
          end
        end
        A_WAIT_DATA: begin
          if (finish) a_state <= A_IDLE;
        end
        default: a_state <= A_IDLE;
      endcase
    end
  end

  // Read sequencer and beat packer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_rd_en   <= '0;
      buf_rd_addr <= '0;
      pe_sel_q    <= '0;
      rd_ptr      <= '0;
      rd_left     <= '0;
      nxt_idx     <= '0;
      pk_idx      <= '0;
      asm_cnt     <= '0;
      rd_vld      <= 1'b0;
      pack_q      <= '0;
      wb_idx      <= '0;
      burst_q     <= '0;
    end else if (start_ok && !zero_cfg) begin
      // First read goes out in the cycle right after start.
      buf_rd_en   <= PE_NUM'(1) << conf_pe_sel;
      buf_rd_addr <= conf_buf_addr;
      pe_sel_q    <= conf_pe_sel;
      rd_ptr      <= ptr_inc(conf_buf_addr);
      rd_left     <= total_reads - TOT_W'(1);
      nxt_idx     <= idx_inc('0);
      pk_idx      <= '0;
      asm_cnt     <= CNT_W'(1);
      rd_vld      <= 1'b0;
      wb_idx      <= '0;
      burst_q     <= conf_burst;
    end else begin
      rd_vld <= (buf_rd_en != '0);
      if (can_issue) begin
        buf_rd_en   <= PE_NUM'(1) << pe_sel_q;
        buf_rd_addr <= rd_ptr;
        rd_ptr      <= ptr_inc(rd_ptr);
        rd_left     <= rd_left - TOT_W'(1);
        nxt_idx     <= idx_inc(nxt_idx);
      end else begin
        buf_rd_en <= '0;
      end
      asm_cnt <= asm_cnt + CNT_W'(can_issue && !beat_open) - CNT_W'(push);
      if (rd_vld) begin
        if (pk_idx == LAST_IDX) begin
          pk_idx <= '0;
          wb_idx <= push_last ? '0 : wb_idx + BURST_W'(1);
        end else begin
          pack_q[pk_idx*RD_W +: RD_W] <= buf_rd_data;
          pk_idx <= pk_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe2ddr_wr.sv
// Testbench for pe2ddr_wr: table of directed transfers with hand-computed
// latencies and counts, plus stall, address-hold, reset and restart sequences.
module tb_pe2ddr_wr;
  import pe2ddr_wr_pkg::*;

  localparam int unsigned BUF_DEPTH  = 256;
  localparam int unsigned PE_NUM     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned RD_W       = DATA_W * BATCH;
  localparam int unsigned RATIO      = DDR_W / RD_W;

  logic                     clk, rst, start, done, busy;
  logic [DDR_ADDR_W-1:0]    conf_st_addr, conf_step;
  logic [BURST_W-1:0]       conf_burst, conf_burst_num;
  logic [bw(PE_NUM)-1:0]    conf_pe_sel;
  logic [bw(BUF_DEPTH)-1:0] conf_buf_addr;
  logic [PE_NUM-1:0]        buf_rd_en;
  logic [bw(BUF_DEPTH)-1:0] buf_rd_addr;
  logic [RD_W-1:0]          buf_rd_data;
  logic [DDR_ADDR_W-1:0]    ddr_addr;
  logic [BURST_W-1:0]       ddr_size;
  logic                     ddr_addr_valid, ddr_addr_ready;
  logic [DDR_W-1:0]         ddr_wr_data;
  logic                     ddr_wr_last, ddr_wr_valid, ddr_wr_ready;

  pe2ddr_wr #(
    .BUF_DEPTH  (BUF_DEPTH),
    .PE_NUM     (PE_NUM),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .busy           (busy),
    .conf_st_addr   (conf_st_addr),
    .conf_step      (conf_step),
    .conf_burst     (conf_burst),
    .conf_burst_num (conf_burst_num),
    .conf_pe_sel    (conf_pe_sel),
    .conf_buf_addr  (conf_buf_addr),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .ddr_addr       (ddr_addr),
    .ddr_size       (ddr_size),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr_ready (ddr_addr_ready),
    .ddr_wr_data    (ddr_wr_data),
    .ddr_wr_last    (ddr_wr_last),
    .ddr_wr_valid   (ddr_wr_valid),
    .ddr_wr_ready   (ddr_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st;
    logic [31:0] step;
    int burst, bnum, pe, baddr;
    int exp_done, exp_addrs, exp_beats, exp_reads;
    int exp_first_rd, exp_first_av, exp_first_wr;
  } vec_t;

  vec_t       vecs [6];
  vec_t       cur;
  logic [7:0] tag;
  int checks, errors;
  int rel, n_rd, n_addr, n_beat, n_done, done_rel;
  int first_rd, first_av, first_wr, last_addr_rel, last_wr_rel, beats_at_addr0;

  // Buffer contents: unique per (tag, pe, address).
  function automatic logic [RD_W-1:0] word(input int pe, input int addr, input logic [7:0] t);
    logic [31:0] w;
    w = {t, 8'(pe), 8'(addr), 8'(addr) ^ 8'h5A};
    return RD_W'(w);
  endfunction

  function automatic int oh_idx(input logic [PE_NUM-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < PE_NUM; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One-cycle-latency buffer read port.
  always @(posedge clk) begin
    if (buf_rd_en != '0) buf_rd_data <= word(oh_idx(buf_rd_en), int'(buf_rd_addr), tag);
  end

  function automatic logic [DDR_W:0] exp_beat(input int j);
    logic [DDR_W-1:0] d;
    d = '0;
    for (int i = 0; i < RATIO; i++)
      d[i*RD_W +: RD_W] = word(cur.pe, (cur.baddr + j*RATIO + i) % BUF_DEPTH, tag);
    return {((j + 1) % cur.burst) == 0, d};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [PE_NUM-1:0] oh;
    logic [31:0]       ea;
    logic [DDR_W:0]    eb;
    if (done) begin
      n_done++;
      if (done_rel == 0) done_rel = rel;
      chk("busy_low_at_done", busy, 0);
    end
    if (buf_rd_en != '0) begin
      if (first_rd == 0) first_rd = rel;
      oh = '0;
      oh[cur.pe] = 1'b1;
      chk("rd_en_onehot", buf_rd_en, oh);
      chk("rd_addr", buf_rd_addr, (cur.baddr + n_rd) % BUF_DEPTH);
      n_rd++;
    end
    if (ddr_addr_valid) begin
      if (first_av == 0) first_av = rel;
      if (ddr_addr_ready) begin
        ea = cur.st + 32'(n_addr) * cur.step;
        chk("ddr_addr", ddr_addr, ea);
        chk("ddr_size", ddr_size, cur.burst);
        if (n_addr == 0) beats_at_addr0 = n_beat;
        n_addr++;
        last_addr_rel = rel;
      end
    end
    if (ddr_wr_valid) begin
      if (first_wr == 0) first_wr = rel;
      if (ddr_wr_ready) begin
        eb = exp_beat(n_beat);
        chk("wr_data", ddr_wr_data, eb[DDR_W-1:0]);
        chk("wr_last", ddr_wr_last, eb[DDR_W]);
        n_beat++;
        last_wr_rel = rel;
      end
    end
  endtask

  // Sample at the falling edge, then step to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk(name, {done, busy, buf_rd_en, buf_rd_addr, ddr_addr, ddr_size, ddr_addr_valid,
               ddr_wr_data, ddr_wr_last, ddr_wr_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input vec_t v, input logic [7:0] t);
    cur = v;
    tag = t;
    n_rd = 0; n_addr = 0; n_beat = 0; n_done = 0; done_rel = 0;
    first_rd = 0; first_av = 0; first_wr = 0;
    last_addr_rel = 0; last_wr_rel = 0; beats_at_addr0 = -1;
    conf_st_addr   = v.st;
    conf_step      = v.step;
    conf_burst     = 8'(v.burst);
    conf_burst_num = 8'(v.bnum);
    conf_pe_sel    = 5'(v.pe);
    conf_buf_addr  = 8'(v.baddr);
    ddr_addr_ready = 1'b1;
    ddr_wr_ready   = 1'b1;
    start = 1'b1;
    rel = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int budget, input int stall_from, input int stall_len,
                     input bit addr_hold, input int rst_beat, input int restart_at,
                     output bit aborted);
    aborted = 1'b0;
    while (done_rel == 0 && rel < budget) begin
      ddr_wr_ready   = !(rel >= stall_from && rel < stall_from + stall_len);
      ddr_addr_ready = !addr_hold || (n_beat >= cur.burst * cur.bnum);
      if (stall_len > 0 && rel == stall_from + stall_len)
        chk("stall_fifo_fill_reads", n_rd, (n_beat + FIFO_DEPTH) * RATIO);
      if (rel == restart_at) begin
        start          = 1'b1;
        conf_st_addr   = 32'hDEAD_0000;
        conf_burst     = 8'd7;
        conf_burst_num = 8'd9;
        conf_pe_sel    = 5'd3;
        conf_buf_addr  = 8'd0;
      end else begin
        start = 1'b0;
      end
      if (rst_beat >= 0 && n_beat == rst_beat) begin
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      tick();
    end
    start = 1'b0;
    if (done_rel == 0 && !aborted) chk("done_timeout", 0, 1);
  endtask

  task automatic check_totals(input string pfx, input int e_addrs, input int e_beats, input int e_reads);
    chk({pfx, "_n_done"}, n_done, 1);
    chk({pfx, "_n_addr"}, n_addr, e_addrs);
    chk({pfx, "_n_beat"}, n_beat, e_beats);
    chk({pfx, "_n_rd"}, n_rd, e_reads);
  endtask

  initial begin
    bit ab;
    vec_t v;
    checks = 0;
    errors = 0;
    rel = 0;
    tag = 8'h00;
    cur = '{32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b0;
    start = 1'b0;
    conf_st_addr = '0; conf_step = '0; conf_burst = '0; conf_burst_num = '0;
    conf_pe_sel = '0; conf_buf_addr = '0;
    ddr_addr_ready = 1'b1;
    ddr_wr_ready = 1'b1;

    //            st            step          bur bn pe  badr done adr beat rd  frd fav fwr
    vecs[0] = '{32'h0000_1000, 32'h0000_0100, 4, 3, 5,  10,  51,  3, 12, 48, 1,  1,  6};
    vecs[1] = '{32'h0000_1000, 32'h0000_0100, 4, 0, 5,  10,  1,   0, 0,  0,  0,  0,  0};
    vecs[2] = '{32'h0000_2000, 32'h0000_0040, 0, 3, 1,  0,   1,   0, 0,  0,  0,  0,  0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0008, 1, 1, 7,  254, 7,   1, 1,  4,  1,  1,  6};
    vecs[4] = '{32'h0000_0020, 32'hFFFF_FFF0, 2, 5, 31, 100, 43,  5, 10, 40, 1,  1,  6};
    vecs[5] = '{32'hFFFF_FF00, 32'h0000_0080, 3, 2, 0,  200, 27,  2, 6,  24, 1,  1,  6};

    @(posedge clk);
    #1;
    check_idle("reset_idle_a");
    check_idle("reset_idle_b");
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      start_xfer(vecs[k], 8'(k + 1));
      run(400, 0, 0, 1'b0, -1, -1, ab);
      repeat (5) tick();
      chk("done_cycle", done_rel, vecs[k].exp_done);
      check_totals("vec", vecs[k].exp_addrs, vecs[k].exp_beats, vecs[k].exp_reads);
      chk("first_rd_en_cycle", first_rd, vecs[k].exp_first_rd);
      chk("first_addr_valid_cycle", first_av, vecs[k].exp_first_av);
      chk("first_wr_valid_cycle", first_wr, vecs[k].exp_first_wr);
      if (vecs[k].exp_beats > 0) chk("done_after_last_beat", done_rel, last_wr_rel + 1);
    end

    // Write-data backpressure: FIFO fills to its depth, then drains in order.
    start_xfer(vecs[0], 8'h40);
    run(600, 15, 30, 1'b0, -1, -1, ab);
    repeat (5) tick();
    check_totals("stall", 3, 12, 48);

    // Address channel held off until every beat has gone out.
    start_xfer(vecs[0], 8'h41);
    run(600, 0, 0, 1'b1, -1, -1, ab);
    repeat (5) tick();
    check_totals("addr_hold", 3, 12, 48);
    chk("addr_hold_beats_before_addr", beats_at_addr0, 12);
    chk("addr_hold_done_after_addr", done_rel, last_addr_rel + 1);

    // Reset in the middle of a transfer.
    start_xfer(vecs[0], 8'h50);
    run(600, 0, 0, 1'b0, 5, -1, ab);
    chk("reset_reached_beat5", ab, 1);
    check_idle("midreset_idle_a");
    check_idle("midreset_idle_b");
    check_idle("midreset_idle_c");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fresh transfer after reset, with an extra start pulse while busy.
    v = '{32'h0000_8000, 32'h0000_0020, 2, 2, 12, 60, 19, 2, 4, 16, 1, 1, 6};
    start_xfer(v, 8'h60);
    run(400, 0, 0, 1'b0, -1, 5, ab);
    repeat (8) tick();
    chk("restart_done_cycle", done_rel, 19);
    check_totals("restart", 2, 4, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
